chunked_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register between chunks. It generalises the team's 4-bit combinational adder into a sequential, handshaked datapath unit. It adds a subtract mode, carry-out and signed-overflow flags, and optional saturation. It sits between operand registers and a result consumer that waits for `done`.

---
 rtl/chunked_addsub.sv | 106 ++++++++++
 tb/tb_chunked_addsub.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// Sequential WIDTH-bit adder/subtractor computing CHUNK bits per cycle with a rippled carry register.
// Optional saturation on signed overflow is built when CHUNKED_ADDSUB_SAT_EN is defined.
module chunked_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int L    = WIDTH / CHUNK;
   localparam int IDXW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic              load, last;
   logic [WIDTH-1:0]  a_reg, b_reg, acc, acc_nxt, s_nxt;
   logic [IDXW-1:0]   idx;
   logic              carry, sign_a;
   logic [CHUNK-1:0]  ca, cb;
   logic [CHUNK:0]    csum;
   logic              c_msb, ovf_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      load = (state == IDLE) && start;
      last = (idx == IDXW'(L - 1));
   end

   // One chunk per cycle; carry into the MSB is recovered from the chunk's top bits.
   always_comb begin
      ca      = a_reg[idx*CHUNK +: CHUNK];
      cb      = b_reg[idx*CHUNK +: CHUNK];
      csum    = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
      acc_nxt = acc;
      acc_nxt[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
      c_msb   = csum[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
      ovf_nxt = c_msb ^ csum[CHUNK];
      s_nxt   = acc_nxt;
`ifdef CHUNKED_ADDSUB_SAT_EN
      if (ovf_nxt)
         s_nxt = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         acc    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         sign_a <= 1'b0;
         s      <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a_reg  <= a;
            b_reg  <= b ^ {WIDTH{sub}};
            carry  <= sub;
            idx    <= '0;
            sign_a <= a[WIDTH-1];
            acc    <= '0;
         end else if (busy) begin
            acc   <= acc_nxt;
            carry <= csum[CHUNK];
            idx   <= idx + 1'b1;
            if (last) begin
               idx  <= '0;
               s    <= s_nxt;
               cout <= csum[CHUNK];
               ovf  <= ovf_nxt;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub (WIDTH=16, CHUNK=4): directed table, handshake sequences, random ops vs. model.
module tb_chunked_addsub;

   localparam int W = 16;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst, start, sub;
   logic [W-1:0] a, b;
   logic         busy, done, cout, ovf;
   logic [W-1:0] s;

   int checks = 0;
   int errors = 0;

   chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vsub;
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference from signed/unsigned integer arithmetic.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
      int xs, ys, r;
      xs = int'($signed(x));
      ys = int'($signed(y));
      r  = sb ? xs - ys : xs + ys;
      ro = (r > 32767) || (r < -32768);
      rc = sb ? (x >= y) : ((int'(x) + int'(y)) > 65535);
      rs = r[W-1:0];
`ifdef CHUNKED_ADDSUB_SAT_EN
      if (ro) rs = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
   endtask

   // Called #1 after an edge; leaves the bench #1 after the edge that raised done.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb,
                         output int lat, output int bcnt);
      start = 1'b1; a = x; b = y; sub = sb;
      @(posedge clk); #1;
      start = 1'b0; a = ~x; b = ~y; sub = ~sb;
      lat = 0; bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic sb, input int lat, input int bcnt);
      logic [W-1:0] es;
      logic ec, eo;
      model(x, y, sb, es, ec, eo);
      chk({tag, " latency"}, lat, LAT);
      chk({tag, " busy_cycles"}, bcnt, LAT);
      chk({tag, " s"}, s, es);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " ovf"}, ovf, eo);
      chk({tag, " busy_at_done"}, busy, 0);
   endtask

   task automatic no_done_for(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      vec_t tbl[7];
      int lat, bcnt;
      logic [W-1:0] ra, rb, es;
      logic rsb, ec, eo;

      tbl[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h000A, 1'b0, 16'h0009, 1'b1, 1'b0};
      tbl[3] = '{16'h0005, 16'h000C, 1'b1, 16'hFFF9, 1'b0, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
`ifdef CHUNKED_ADDSUB_SAT_EN
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset s", s, 0);
      chk("reset cout", cout, 0);
      chk("reset ovf", ovf, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_op(tbl[i].va, tbl[i].vb, tbl[i].vsub, lat, bcnt);
         chk($sformatf("vec%0d latency", i), lat, LAT);
         chk($sformatf("vec%0d busy_cycles", i), bcnt, LAT);
         chk($sformatf("vec%0d s", i), s, tbl[i].es);
         chk($sformatf("vec%0d cout", i), cout, tbl[i].ec);
         chk($sformatf("vec%0d ovf", i), ovf, tbl[i].eo);
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("vec%0d s_hold", i), s, tbl[i].es);
      end

      // start during the 2nd RUN cycle is ignored and not queued
      start = 1'b1; a = 16'h1234; b = 16'h0101; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 2;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("ignored_start latency", lat, LAT);
      chk("ignored_start s", s, 16'h1335);
      no_done_for("ignored_start not_queued", 8);
      chk("ignored_start s_hold", s, 16'h1335);

      // back-to-back: start asserted in the done cycle
      run_op(16'h0F0F, 16'h00F1, 1'b0, lat, bcnt);
      check_op("b2b first", 16'h0F0F, 16'h00F1, 1'b0, lat, bcnt);
      run_op(16'h0100, 16'h0200, 1'b1, lat, bcnt);
      check_op("b2b second", 16'h0100, 16'h0200, 1'b1, lat, bcnt);
      @(posedge clk); #1;

      // reset in the 2nd RUN cycle aborts with no done
      start = 1'b1; a = 16'h4000; b = 16'h0003; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort s", s, 0);
      chk("abort cout", cout, 0);
      no_done_for("abort no_done", 8);

      // reset wins over start in the same cycle
      rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_priority busy", busy, 0);
      no_done_for("rst_priority no_done", 6);

      for (int i = 0; i < 40; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rsb = 1'($urandom);
         if (i % 8 == 0) ra = {1'b0, {(W-1){1'b1}}};
         if (i % 8 == 1) ra = {1'b1, {(W-1){1'b0}}};
         run_op(ra, rb, rsb, lat, bcnt);
         model(ra, rb, rsb, es, ec, eo);
         chk($sformatf("rand%0d latency", i), lat, LAT);
         chk($sformatf("rand%0d s", i), s, es);
         chk($sformatf("rand%0d cout", i), cout, ec);
         chk($sformatf("rand%0d ovf", i), ovf, eo);
         if (i % 3 == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
